servo_pwm_array: RTL and testbench



---
 rtl/servo_pwm_array.sv | 116 +++++++++++
 tb/tb_servo_pwm_array.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator with an Avalon-MM register slave.
// One shared frame counter; per-channel clamped target, slew-limited active width and enable.
module servo_pwm_array #(
  parameter int NUM_CH       = 8,
  parameter int CNT_W        = 20,
  parameter int PERIOD_TICKS = 1000000,
  parameter int MIN_PW       = 50000,
  parameter int MAX_PW       = 100000,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0]  MIN_V    = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0]  MAX_V    = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0]  CENTER   = CNT_W'((MIN_PW + MAX_PW) / 2);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_FRAMES = ADDR_W'(3);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  step;
  logic [31:0]       frames;
  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] en_act;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] wr_tgt;
  logic [CNT_W-1:0]  tgt      [NUM_CH];
  logic [CNT_W-1:0]  act      [NUM_CH];
  logic [CNT_W-1:0]  act_next [NUM_CH];
  logic [CNT_W-1:0]  wd;
  logic [CNT_W-1:0]  wd_clamped;
  logic [31:0]       rd_mux;
  logic              wrap;
  logic              wr_ctrl;
  logic              wr_step;
  logic              unused_wdata;

  // Bus semantics: a write commits at the edge where avs_write is sampled (no
  // waitrequest); a read presents data on avs_readdata one cycle after avs_read
  // and the value holds until the next read. A same-cycle read sees old contents.
  assign wrap         = (cnt == LAST);
  assign wr_ctrl      = avs_write && (avs_address == A_CTRL);
  assign wr_step      = avs_write && (avs_address == A_STEP);
  assign wd           = avs_writedata[CNT_W-1:0];
  assign wd_clamped   = (wd < MIN_V) ? MIN_V : ((wd > MAX_V) ? MAX_V : wd);
  assign unused_wdata = ^avs_writedata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] mag;

    assign diff = $signed({1'b0, tgt[g]}) - $signed({1'b0, act[g]});
    assign mag  = diff[CNT_W] ? -diff : diff;
    // |d| > STEP implies a full STEP never overshoots the target, so act stays in range.
    assign act_next[g] = ((step == '0) || ($unsigned(mag) <= {1'b0, step})) ? tgt[g] :
                         (diff[CNT_W] ? (act[g] - step) : (act[g] + step));
    assign status[g] = (act[g] == tgt[g]);
    assign wr_tgt[g] = avs_write && (avs_address == ADDR_W'(4 + g));
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_CTRL:   rd_mux = 32'(ctrl);
      A_STEP:   rd_mux = 32'(step);
      A_STATUS: rd_mux = 32'(status);
      A_FRAMES: rd_mux = frames;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (avs_address == ADDR_W'(4 + i)) rd_mux = 32'(tgt[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      frames       <= '0;
      ctrl         <= '0;
      step         <= '0;
      en_act       <= '0;
      pwm_out      <= '0;
      avs_readdata <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= CENTER;
        act[i] <= CENTER;
      end
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        frames <= frames + 32'd1;
        en_act <= ctrl;
        for (int i = 0; i < NUM_CH; i++) act[i] <= act_next[i];
      end
      for (int i = 0; i < NUM_CH; i++) pwm_out[i] <= en_act[i] && (cnt < act[i]);
      if (avs_read) avs_readdata <= rd_mux;
      if (wr_ctrl) ctrl <= avs_writedata[NUM_CH-1:0];
      if (wr_step) step <= wd;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_tgt[i]) tgt[i] <= wd_clamped;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array: frame-level behavioural model checked every
// cycle, plus literal pulse widths and register reads.
module tb_servo_pwm_array;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 20;
  localparam int P      = 100;
  localparam int MIN_PW = 10;
  localparam int MAX_PW = 40;
  localparam int ADDR_W = 5;
  localparam int CENTER = (MIN_PW + MAX_PW) / 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] pwm_out;

  int total = 0;
  int bad   = 0;

  servo_pwm_array #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_TICKS(P),
    .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .pwm_out(pwm_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model state: ph is the position inside the current frame
  int                m_ctrl, m_step, ph;
  int                m_tgt [NUM_CH];
  int                m_act [NUM_CH];
  bit                m_en  [NUM_CH];
  logic [31:0]       m_frames;
  logic [NUM_CH-1:0] exp_pwm = '0;
  bit                rd_pend = 0;
  bit                started = 0;
  logic [31:0]       exp_q[$];
  int                mw [NUM_CH];

  function automatic int clamp(logic [31:0] v);
    int x;
    x = int'(v & 32'h000F_FFFF);
    if (x < MIN_PW) return MIN_PW;
    if (x > MAX_PW) return MAX_PW;
    return x;
  endfunction

  function automatic int slew(int a, int t, int s);
    int d;
    int mag;
    d = t - a;
    mag = (d < 0) ? -d : d;
    if (s == 0 || mag <= s) return t;
    return (d > 0) ? a + s : a - s;
  endfunction

  function automatic logic [31:0] model_read(int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) r = 32'(m_ctrl);
    else if (a == 1) r = 32'(m_step);
    else if (a == 2) begin
      for (int i = 0; i < NUM_CH; i++) r[i] = (m_act[i] == m_tgt[i]);
    end
    else if (a == 3) r = m_frames;
    else if (a >= 4 && a < 4 + NUM_CH) r = 32'(m_tgt[a-4]);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      started = 1; m_ctrl = 0; m_step = 0; m_frames = '0; ph = 0;
      exp_pwm = '0; rd_pend = 0; exp_q.delete();
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i] = 0; m_tgt[i] = CENTER; m_act[i] = CENTER;
      end
    end else begin
      rd_pend = avs_read;
      if (avs_read) exp_q.push_back(model_read(int'(avs_address)));
      // the pulse for this frame position is high while position < width
      for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = m_en[i] && (ph < m_act[i]);
      if (ph == P - 1) begin
        ph = 0;
        m_frames = m_frames + 1;
        for (int i = 0; i < NUM_CH; i++) begin
          m_en[i]  = m_ctrl[i];
          m_act[i] = slew(m_act[i], m_tgt[i], m_step);
        end
      end else begin
        ph = ph + 1;
      end
      if (avs_write) begin
        if (avs_address == 0) m_ctrl = int'(avs_writedata & ((32'd1 << NUM_CH) - 1));
        else if (avs_address == 1) m_step = int'(avs_writedata & 32'h000F_FFFF);
        else if (avs_address >= 4 && avs_address < 4 + NUM_CH)
          m_tgt[avs_address-4] = clamp(avs_writedata);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  // scoreboard compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("pwm_model", 32'(pwm_out), 32'(exp_pwm));
      if (rd_pend) begin
        if (exp_q.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
        else chk("rd_model", avs_readdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    avs_address = ADDR_W'(a); avs_writedata = d; avs_write = 1'b1;
    step(1);
    avs_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] e);
    avs_address = ADDR_W'(a); avs_read = 1'b1;
    step(1);
    avs_read = 1'b0;
    chk(nm, avs_readdata, e);
  endtask

  task automatic wait_ph(input int v);
    int n;
    n = 0;
    while (ph != v && n < 3 * P) begin
      step(1);
      n++;
    end
    if (ph != v) begin
      total++; bad++;
      $display("FAIL wait_ph: phase %0d required %0d", ph, v);
    end
  endtask

  task automatic measure();
    wait_ph(0);
    for (int i = 0; i < NUM_CH; i++) mw[i] = 0;
    for (int k = 0; k < P; k++) begin
      step(1);
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) mw[i]++;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int hi;
    step(3);
    reset = 1'b0;

    // reset values
    for (int i = 0; i < NUM_CH; i++) rd_chk("reset_tgt", 4 + i, 32'd25);
    rd_chk("reset_ctrl", 0, 32'd0);
    rd_chk("reset_step", 1, 32'd0);
    rd_chk("reset_frames", 3, 32'd0);
    rd_chk("reset_status", 2, 32'hF);
    hi = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      if (pwm_out != 0) hi++;
    end
    chk("idle_pwm", 32'(hi), 32'd0);

    // enable and target
    wr(0, 32'h1);
    wr(4, 32'd30);
    measure();
    chk("en_w0", 32'(mw[0]), 32'd30);
    chk("en_w1", 32'(mw[1]), 32'd0);
    chk("en_w3", 32'(mw[3]), 32'd0);

    // clamp
    wr(5, 32'd5);
    wr(6, 32'd1000);
    rd_chk("clamp_lo", 5, 32'd10);
    rd_chk("clamp_hi", 6, 32'd40);
    wr(0, 32'h7);
    measure();
    chk("clamp_w0", 32'(mw[0]), 32'd30);
    chk("clamp_w1", 32'(mw[1]), 32'd10);
    chk("clamp_w2", 32'(mw[2]), 32'd40);

    // slew: act0 back to 25, then step 4 toward 38
    wr(4, 32'd25);
    wait_ph(0);
    wr(1, 32'd4);
    wr(4, 32'd38);
    rd_chk("slew_status_clr", 2, 32'hE);
    measure(); chk("slew_w1", 32'(mw[0]), 32'd29);
    measure(); chk("slew_w2", 32'(mw[0]), 32'd33);
    measure(); chk("slew_w3", 32'(mw[0]), 32'd37);
    measure(); chk("slew_w4", 32'(mw[0]), 32'd38);
    rd_chk("slew_status_set", 2, 32'hF);
    wr(1, 32'd0);

    // target written on the boundary cycle lands one frame later
    wait_ph(P - 1);
    avs_address = ADDR_W'(4); avs_writedata = 32'd15; avs_write = 1'b1;
    step(1);
    avs_write = 1'b0;
    measure(); chk("coll_old", 32'(mw[0]), 32'd38);
    measure(); chk("coll_new", 32'(mw[0]), 32'd15);

    // disable mid-pulse: pulses in flight complete
    for (int i = 0; i < NUM_CH; i++) mw[i] = 0;
    for (int k = 0; k < P; k++) begin
      if (k == 5) begin
        avs_address = ADDR_W'(0); avs_writedata = 32'h0; avs_write = 1'b1;
      end
      step(1);
      avs_write = 1'b0;
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) mw[i]++;
    end
    chk("dis_w0", 32'(mw[0]), 32'd15);
    chk("dis_w2", 32'(mw[2]), 32'd40);
    measure();
    chk("dis_after_w0", 32'(mw[0]), 32'd0);
    chk("dis_after_w2", 32'(mw[2]), 32'd0);

    // reset in the middle of a pulse
    wr(0, 32'h1);
    wait_ph(0);
    wait_ph(5);
    chk("pre_reset_pwm", 32'(pwm_out[0]), 32'd1);
    reset = 1'b1;
    step(1);
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    reset = 1'b0;
    rd_chk("rst2_ctrl", 0, 32'd0);
    rd_chk("rst2_step", 1, 32'd0);
    rd_chk("rst2_tgt0", 4, 32'd25);
    rd_chk("rst2_frames", 3, 32'd0);
    repeat (3) begin
      wait_ph(P - 1);
      step(1);
    end
    rd_chk("frames_3", 3, 32'd3);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
